// File: rtl/hold_zero_sync.sv
// Holding-zero front end for the ADC sine channel.
// Converts each accepted sample to the selected output code, tracks the
// hysteretic, debounced sign of the waveform (Sync), and measures the
// excitation period between rising crossings to flag a stable lock.
module hold_zero_sync #(
  parameter int DATA_W   = 14,
  parameter int HYST     = 64,
  parameter int DEBOUNCE = 2,
  parameter int PERIOD_W = 16,
  parameter int TOL      = 2,
  parameter int LOCK_N   = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic signed [DATA_W-1:0] SinIn,
  input  logic                     InValid,
  input  logic                     CodeSel,
  output logic [DATA_W-1:0]        SinOut,
  output logic                     OutValid,
  output logic                     Sync,
  output logic                     SyncPulse,
  output logic [PERIOD_W-1:0]      Period,
  output logic                     PeriodValid,
  output logic                     Locked
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int M_W  = $clog2(LOCK_N + 1);

  // Thresholds live one bit wider than the sample so -HYST never wraps.
  localparam logic signed [DATA_W:0] HYST_POS = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] HYST_NEG = -HYST_POS;

  localparam logic [DB_W-1:0]     DB_MAX     = DB_W'(DEBOUNCE);
  localparam logic [M_W-1:0]      LOCK_MAX   = M_W'(LOCK_N);
  localparam logic [PERIOD_W-1:0] PERIOD_SAT = '1;
  localparam logic [PERIOD_W-1:0] PERIOD_TOL = PERIOD_W'(TOL);

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    POS     = 2'd1,
    NEG     = 2'd2
  } state_t;

  // Offset binary flips the sign bit; two's complement passes through.
  function automatic logic [DATA_W-1:0] convertCode(
    input logic signed [DATA_W-1:0] x,
    input logic                     twos
  );
    logic [DATA_W-1:0] raw;
    raw = x;
    convertCode = twos ? raw : {~raw[DATA_W-1], raw[DATA_W-2:0]};
  endfunction

  // Sample counter increment that sticks at all-ones.
  function automatic logic [PERIOD_W-1:0] satInc(input logic [PERIOD_W-1:0] c);
    satInc = (c == PERIOD_SAT) ? c : c + PERIOD_W'(1);
  endfunction

  // Unsigned magnitude of the difference between two periods.
  function automatic logic [PERIOD_W-1:0] absDiff(
    input logic [PERIOD_W-1:0] a,
    input logic [PERIOD_W-1:0] b
  );
    absDiff = (a >= b) ? a - b : b - a;
  endfunction

  // ---- stage p0: classify the incoming sample and decide the next state
  logic signed [DATA_W:0] sinExt_p0;
  logic                   isPos_p0;
  logic                   isNeg_p0;

  state_t                 state;
  state_t                 stateNext;
  logic [DB_W-1:0]        dbCnt;
  logic [DB_W-1:0]        dbNext;
  logic [DB_W-1:0]        runLen;
  logic                   runPos;
  logic                   runPosNext;
  logic                   rise_p0;

  logic [PERIOD_W-1:0]    sampCnt;
  logic [PERIOD_W-1:0]    cntNext_p0;
  logic                   seenRise;
  logic [PERIOD_W-1:0]    prevPeriod;
  logic                   prevValid;
  logic [M_W-1:0]         matchCnt;
  logic [M_W-1:0]         matchNext_p0;

  logic [DATA_W-1:0]      sinOut_p1;
  logic                   vld_p1;
  logic                   sync_p1;
  logic                   syncPulse_p1;
  logic [PERIOD_W-1:0]    period_p1;
  logic                   periodVld_p1;
  logic                   locked_p1;

  assign sinExt_p0 = {SinIn[DATA_W-1], SinIn};
  assign isPos_p0  = (sinExt_p0 >= HYST_POS);
  assign isNeg_p0  = (sinExt_p0 <  HYST_NEG);

  // Debounced hysteresis decision: a state change needs DEBOUNCE back-to-back
  // qualifying samples; anything else breaks the run.
  always_comb begin
    stateNext  = state;
    dbNext     = dbCnt;
    runPosNext = runPos;
    runLen     = dbCnt + DB_W'(1);
    if (InValid) begin
      case (state)
        UNKNOWN: begin
          if (isPos_p0 || isNeg_p0) begin
            // A run in UNKNOWN continues only if it has the same sign.
            runLen     = ((isPos_p0 == runPos) && (dbCnt != '0)) ? dbCnt + DB_W'(1) : DB_W'(1);
            runPosNext = isPos_p0;
            if (runLen >= DB_MAX) begin
              stateNext = isPos_p0 ? POS : NEG;
              dbNext    = '0;
            end else begin
              dbNext = runLen;
            end
          end else begin
            dbNext = '0;
          end
        end
        POS: begin
          if (isNeg_p0) begin
            if (runLen >= DB_MAX) begin
              stateNext = NEG;
              dbNext    = '0;
            end else begin
              dbNext = runLen;
            end
          end else begin
            dbNext = '0;
          end
        end
        NEG: begin
          if (isPos_p0) begin
            if (runLen >= DB_MAX) begin
              stateNext = POS;
              dbNext    = '0;
            end else begin
              dbNext = runLen;
            end
          end else begin
            dbNext = '0;
          end
        end
        default: begin
          stateNext = UNKNOWN;
          dbNext    = '0;
        end
      endcase
    end
  end

  assign rise_p0    = InValid && (state == NEG) && (stateNext == POS);
  assign cntNext_p0 = satInc(sampCnt);

  // Lock qualification for the period being closed by this crossing.
  always_comb begin
    matchNext_p0 = '0;
    if (prevValid && (cntNext_p0 != PERIOD_SAT) &&
        (absDiff(cntNext_p0, prevPeriod) <= PERIOD_TOL)) begin
      matchNext_p0 = (matchCnt == LOCK_MAX) ? matchCnt : matchCnt + M_W'(1);
    end
  end

  // ---- stage p1: registered outputs
  // Zero-crossing FSM with its registered Sync level and crossing pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= UNKNOWN;
      dbCnt        <= '0;
      runPos       <= 1'b0;
      sync_p1      <= 1'b0;
      syncPulse_p1 <= 1'b0;
    end else begin
      state        <= stateNext;
      dbCnt        <= dbNext;
      runPos       <= runPosNext;
      sync_p1      <= (stateNext == NEG);
      syncPulse_p1 <= rise_p0;
    end
  end

  // Code conversion; SinOut holds between accepted samples.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sinOut_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= InValid;
      if (InValid) begin
        sinOut_p1 <= convertCode(SinIn, CodeSel);
      end
    end
  end

  // Period measurement between rising crossings and lock tracking.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sampCnt      <= '0;
      seenRise     <= 1'b0;
      period_p1    <= '0;
      periodVld_p1 <= 1'b0;
      prevPeriod   <= '0;
      prevValid    <= 1'b0;
      matchCnt     <= '0;
      locked_p1    <= 1'b0;
    end else begin
      periodVld_p1 <= 1'b0;
      if (rise_p0) begin
        sampCnt  <= '0;
        seenRise <= 1'b1;
        // The first crossing after reset only opens the measurement window.
        if (seenRise) begin
          period_p1    <= cntNext_p0;
          periodVld_p1 <= 1'b1;
          matchCnt     <= matchNext_p0;
          locked_p1    <= (matchNext_p0 == LOCK_MAX);
          prevPeriod   <= cntNext_p0;
          prevValid    <= 1'b1;
        end
      end else if (InValid) begin
        sampCnt <= cntNext_p0;
      end
    end
  end

  assign SinOut      = sinOut_p1;
  assign OutValid    = vld_p1;
  assign Sync        = sync_p1;
  assign SyncPulse   = syncPulse_p1;
  assign Period      = period_p1;
  assign PeriodValid = periodVld_p1;
  assign Locked      = locked_p1;

endmodule

// File: tb/tb_hold_zero_sync.sv
// Self-checking bench for hold_zero_sync: random and directed stimulus
// compared cycle by cycle against a sample-history reference model.
module tb_hold_zero_sync;

  localparam int DATA_W   = 14;
  localparam int HYST     = 64;
  localparam int DEBOUNCE = 2;
  localparam int PERIOD_W = 8;
  localparam int TOL      = 2;
  localparam int LOCK_N   = 4;
  localparam int PSAT     = (1 << PERIOD_W) - 1;

  logic                     Clk = 1'b0;
  logic                     Rst_n = 1'b0;
  logic signed [DATA_W-1:0] SinIn = '0;
  logic                     InValid = 1'b0;
  logic                     CodeSel = 1'b0;
  logic [DATA_W-1:0]        SinOut;
  logic                     OutValid;
  logic                     Sync;
  logic                     SyncPulse;
  logic [PERIOD_W-1:0]      Period;
  logic                     PeriodValid;
  logic                     Locked;

  hold_zero_sync #(
    .DATA_W(DATA_W), .HYST(HYST), .DEBOUNCE(DEBOUNCE),
    .PERIOD_W(PERIOD_W), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .SinIn(SinIn), .InValid(InValid), .CodeSel(CodeSel),
    .SinOut(SinOut), .OutValid(OutValid), .Sync(Sync), .SyncPulse(SyncPulse),
    .Period(Period), .PeriodValid(PeriodValid), .Locked(Locked)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: history of sample classes since the last state
  // change, absolute sample index of each rising crossing, and the list of
  // measured periods.
  logic [DATA_W-1:0] eSinOut;
  bit                eOutValid, eSync, eSyncPulse, ePeriodValid, eLocked;
  int                ePeriod;
  int                mState;      // 0 unknown, 1 positive, 2 negative
  int                hist[$];
  int                periods[$];
  int                sampIdx;
  int                lastRise;

  task automatic modelReset();
    eSinOut = '0; eOutValid = 0; eSync = 0; eSyncPulse = 0;
    ePeriodValid = 0; eLocked = 0; ePeriod = 0;
    mState = 0; hist.delete(); periods.delete();
    sampIdx = 0; lastRise = -1;
  endtask

  // Locked iff the last LOCK_N period pairs all agree within TOL and none of
  // those newer periods is saturated.
  function automatic bit lockFromHistory();
    int n;
    int d;
    n = periods.size();
    if (n < LOCK_N + 1) return 1'b0;
    for (int k = n - LOCK_N; k < n; k++) begin
      d = periods[k] - periods[k-1];
      if (d < 0) d = -d;
      if (periods[k] == PSAT || d > TOL) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelStep(input bit v, input int x, input bit cs);
    int  cls;
    int  target;
    int  p;
    bit  same;
    eOutValid    = v;
    eSyncPulse   = 0;
    ePeriodValid = 0;
    if (v) begin
      eSinOut = cs ? DATA_W'(x & 16383) : DATA_W'((x + 8192) & 16383);
      sampIdx++;
      cls = (x >= HYST) ? 1 : ((x < -HYST) ? -1 : 0);
      hist.push_back(cls);
      target = -1;
      if (cls != 0 && hist.size() >= DEBOUNCE) begin
        same = 1;
        for (int k = 1; k <= DEBOUNCE; k++)
          if (hist[hist.size()-k] != cls) same = 0;
        if (same) target = (cls > 0) ? 1 : 2;
      end
      if (target >= 0 && target != mState) begin
        if (mState == 2 && target == 1) begin
          eSyncPulse = 1;
          if (lastRise >= 0) begin
            p = sampIdx - lastRise;
            if (p > PSAT) p = PSAT;
            ePeriod      = p;
            ePeriodValid = 1;
            periods.push_back(p);
            eLocked = lockFromHistory();
          end
          lastRise = sampIdx;
        end
        mState = target;
        hist.delete();
      end
      eSync = (mState == 2);
    end
  endtask

  task automatic checkAll();
    checkEq("SinOut", SinOut, eSinOut);
    checkEq("OutValid", OutValid, eOutValid);
    checkEq("Sync", Sync, eSync);
    checkEq("SyncPulse", SyncPulse, eSyncPulse);
    checkEq("Period", Period, ePeriod);
    checkEq("PeriodValid", PeriodValid, ePeriodValid);
    checkEq("Locked", Locked, eLocked);
  endtask

  // Drive one cycle of input, advance the model, check one clock later.
  task automatic step(input bit v, input int x, input bit cs);
    InValid = v;
    SinIn   = DATA_W'(x);
    CodeSel = cs;
    if (!Rst_n) modelReset();
    else        modelStep(v, x, cs);
    @(posedge Clk);
    #1;
    checkAll();
  endtask

  function automatic int sineAt(input int n);
    real r;
    r = 4000.0 * $sin(6.283185307179586 * n / 100.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int randSample();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  int  rises;
  int  lockRise;
  int  pvSeen;
  int  n;
  int  x;
  int  sel;
  bit  v;
  bit  sp;

  initial begin
    modelReset();

    // Reset held: random traffic must leave every output at zero.
    for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), randSample(), 1'($urandom_range(0, 1)));
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 10, 1'b0);
    checkEq("sync_after_release", Sync, 0);

    // Output coding.
    step(1'b1, -8192, 1'b0);
    checkEq("code_ob_min", SinOut, 14'h0000);
    checkEq("code_outvalid", OutValid, 1);
    step(1'b1, 8191, 1'b0);
    checkEq("code_ob_max", SinOut, 14'h3FFF);
    step(1'b1, -8192, 1'b1);
    checkEq("code_twos", SinOut, 14'h2000);
    step(1'b0, 123, 1'b0);
    checkEq("idle_outvalid", OutValid, 0);
    checkEq("idle_hold", SinOut, 14'h2000);

    // Hysteresis and debounce.
    for (int i = 0; i < 10; i++) step(1'b1, 63, 1'b0);
    checkEq("hy_deadband", Sync, 0);
    step(1'b1, -65, 1'b0);
    checkEq("hy_neg_first", Sync, 0);
    step(1'b1, -65, 1'b0);
    checkEq("hy_neg_second", Sync, 1);
    step(1'b1, 70, 1'b0);
    step(1'b1, -10, 1'b0);
    step(1'b1, 70, 1'b0);
    checkEq("hy_broken_run", Sync, 1);
    step(1'b1, 64, 1'b0);
    sp = SyncPulse;
    step(1'b1, 64, 1'b0);
    sp = sp | SyncPulse;
    checkEq("hy_pos", Sync, 0);
    checkEq("hy_pulse", sp, 1);

    // Random traffic around the thresholds, with gaps and code changes.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       x = randSample();
        1:       x = HYST - 20 + int'($urandom_range(0, 40));
        2:       x = -HYST - 20 + int'($urandom_range(0, 40));
        default: x = ($urandom_range(0, 1) != 0) ? 3000 : -3000;
      endcase
      step(1'($urandom_range(0, 4) != 0), x, 1'($urandom_range(0, 1)));
    end

    // Clean sine, period 100: lock on the sixth rising crossing.
    Rst_n = 1'b0;
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    Rst_n = 1'b1;
    rises = 0;
    lockRise = 0;
    for (int i = 0; i < 700; i++) begin
      step(1'b1, sineAt(i), 1'b0);
      if (SyncPulse) rises++;
      if (PeriodValid) checkEq("sine_period", Period, 100);
      if (Locked && lockRise == 0) lockRise = rises;
    end
    checkEq("lock_rise_index", lockRise, 6);
    checkEq("lock_on", Locked, 1);

    // Long negative hold saturates the period and drops lock.
    for (int i = 0; i < 300; i++) step(1'b1, -500, 1'b0);
    step(1'b1, 500, 1'b0);
    step(1'b1, 500, 1'b0);
    checkEq("sat_pv", PeriodValid, 1);
    checkEq("sat_period", Period, PSAT);
    checkEq("sat_unlock", Locked, 0);

    // Sine with random InValid gaps: period counts accepted samples only.
    n = 0;
    pvSeen = 0;
    while (n < 900) begin
      v = 1'($urandom_range(0, 3) != 0);
      x = v ? sineAt(n) : randSample();
      step(v, x, 1'($urandom_range(0, 1)));
      if (v) n++;
      if (PeriodValid) begin
        pvSeen++;
        if (pvSeen > 1) checkEq("gap_period", Period, 100);
      end
    end
    checkEq("gap_locked", Locked, 1);

    // Asynchronous reset between crossings while locked.
    Rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), randSample(), 1'($urandom_range(0, 1)));
    Rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 251; i++) begin
      step(1'b1, sineAt(i + 30), 1'b0);
      if (SyncPulse) begin
        rises++;
        if (rises == 1) checkEq("first_rise_no_pv", PeriodValid, 0);
      end
    end
    checkEq("rises_after_reset", rises, 2);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
